serial_pattern_detector: RTL and testbench

- Downstream consumer of the single-bit D flip-flop stage: takes the registered serial bit `q` as `din` and detects a parameterised bit pattern in the stream.
- Emits a one-cycle `match` pulse per detection and keeps a saturating count of detections.
- Serves as the first self-checking sink in the flip-flop chain, so benches can score random streams without waveform inspection.

---
 rtl/serial_pattern_detector_pkg.sv | 9 +
 rtl/serial_pattern_detector_sat_counter.sv | 29 ++
 rtl/serial_pattern_detector.sv | 71 +++++++
 tb/tb_serial_pattern_detector.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_detector_pkg.sv
// Shared defaults for the serial pattern detector: pattern constants and
// the default width of the detection counter.
package serial_pattern_detector_pkg;

   localparam int                     PAT_LEN_DEF = 4;
   localparam logic [PAT_LEN_DEF-1:0] PAT_1011    = 4'b1011;
   localparam int                     CNT_W_DEF   = 8;

endpackage : serial_pattern_detector_pkg

// File: rtl/serial_pattern_detector_sat_counter.sv
// Saturating event counter with a sticky overflow flag.
// The count holds at all-ones; an increment arriving while saturated sets ovf,
// which stays set until clr or rst. clr wins over a same-edge increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         ovf
);

   // Count register: reset/clear first, then saturating increment.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (inc) begin
         if (cnt == {W{1'b1}}) begin
            ovf <= 1'b1;
         end else begin
            cnt <= cnt + W'(1);
         end
      end
   end

endmodule : sat_counter

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts in enabled samples of din, flags a
// registered one-cycle match when the last PAT_LEN samples equal PATTERN
// (MSB = oldest bit) and counts detections in a saturating counter.
// A fill counter guards against matching on the zero-initialised history.
module serial_pattern_detector
   import serial_pattern_detector_pkg::*;
#(
   parameter int                 PAT_LEN = PAT_LEN_DEF,
   parameter logic [PAT_LEN-1:0] PATTERN = PAT_1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic             clr_count,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             count_ovf
);

   localparam int                FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

   logic [PAT_LEN-1:0] hist;
   logic [PAT_LEN-1:0] hist_n;
   logic [FILL_W-1:0]  fill;
   logic [FILL_W-1:0]  fill_n;
   logic               hit;

   // Candidate history/fill after an enabled sample and the resulting hit.
   always_comb begin
      hist_n = {hist[PAT_LEN-2:0], din};
      fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
      hit    = en && (fill_n == FILL_FULL) && (hist_n == PATTERN);
   end

   // History, fill and the registered match pulse; non-overlap mode restarts
   // the history after every hit so the next detection needs fresh bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist  <= '0;
         fill  <= '0;
         match <= 1'b0;
      end else begin
         match <= hit;
         if (en) begin
            if (hit && !OVERLAP) begin
               hist <= '0;
               fill <= '0;
            end else begin
               hist <= hist_n;
               fill <= fill_n;
            end
         end
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_count (
      .clk (clk),
      .rst (rst),
      .inc (hit),
      .clr (clr_count),
      .cnt (match_count),
      .ovf (count_ovf)
   );

endmodule : serial_pattern_detector

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector. Three instances share one input stream:
// the default build (overlap, 8-bit count), a non-overlap build and a build
// with a 2-bit counter for saturation. A one-bit flip-flop feeds the
// detector during the random soak, scored against a small reference model.
module tb_serial_pattern_detector;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic din;
   logic din_drv;
   logic clr_count;
   logic use_ff;
   logic ff_d;
   logic ff_q;

   logic       m_ov;
   logic [7:0] cnt_ov;
   logic       ovf_ov;
   logic       m_nov;
   logic [7:0] cnt_nov;
   logic       ovf_nov;
   logic       m_sat;
   logic [1:0] cnt_sat;
   logic       ovf_sat;

   int checks   = 0;
   int failures = 0;
   logic [0:0] exp_q[$];

   // Clock and the upstream flip-flop stage.
   always #5 clk = ~clk;
   always @(posedge clk) ff_q <= ff_d;
   assign din = use_ff ? ff_q : din_drv;

   serial_pattern_detector dut_ov (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr_count(clr_count),
      .match(m_ov), .match_count(cnt_ov), .count_ovf(ovf_ov)
   );

   serial_pattern_detector #(.OVERLAP(1'b0)) dut_nov (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr_count(clr_count),
      .match(m_nov), .match_count(cnt_nov), .count_ovf(ovf_nov)
   );

   serial_pattern_detector #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr_count(clr_count),
      .match(m_sat), .match_count(cnt_sat), .count_ovf(ovf_sat)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs and return #1 after the rising edge.
   task automatic tick(input logic e, input logic d, input logic c);
      en        = e;
      din_drv   = d;
      clr_count = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b1;
      en        = 1'b0;
      clr_count = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One enabled sample, checking the match pulse of both overlap builds.
   task automatic sample(input string tag, input logic d, input logic e_ov, input logic e_nov);
      tick(1'b1, d, 1'b0);
      check({tag, "_match"}, 32'(m_ov), 32'(e_ov));
      check({tag, "_nov_match"}, 32'(m_nov), 32'(e_nov));
   endtask

   initial begin
      logic [15:0] bits;
      logic [15:0] exp_ov;
      logic [15:0] exp_nov;
      int          exp_sc[16];
      int          exp_so[16];
      logic [3:0]  mh;
      int          mf;
      int          mc;
      logic        b;
      logic [0:0]  e;

      use_ff  = 1'b0;
      ff_d    = 1'b0;
      din_drv = 1'b0;

      // Reset and fill guard.
      do_reset(0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_match", 32'(m_ov), 32'd0);
      check("rst_count", 32'(cnt_ov), 32'd0);
      check("rst_ovf", 32'(ovf_ov), 32'd0);
      check("rst_nov_count", 32'(cnt_nov), 32'd0);
      check("rst_sat_count", 32'(cnt_sat), 32'd0);
      check("rst_sat_ovf", 32'(ovf_sat), 32'd0);
      rst = 1'b0;
      sample("fill1", 1'b1, 1'b0, 1'b0);
      sample("fill2", 1'b0, 1'b0, 1'b0);
      sample("fill3", 1'b1, 1'b0, 1'b0);
      sample("fill4", 1'b1, 1'b1, 1'b1);
      check("fill_count", 32'(cnt_ov), 32'd1);
      tick(1'b0, 1'b0, 1'b0);
      check("fill_pulse_end", 32'(m_ov), 32'd0);

      // Overlap vs. non-overlap on 1011011.
      do_reset(1);
      sample("ov1", 1'b1, 1'b0, 1'b0);
      sample("ov2", 1'b0, 1'b0, 1'b0);
      sample("ov3", 1'b1, 1'b0, 1'b0);
      sample("ov4", 1'b1, 1'b1, 1'b1);
      sample("ov5", 1'b0, 1'b0, 1'b0);
      sample("ov6", 1'b1, 1'b0, 1'b0);
      sample("ov7", 1'b1, 1'b1, 1'b0);
      check("ov_count", 32'(cnt_ov), 32'd2);
      check("nov_count", 32'(cnt_nov), 32'd1);

      // Enable gaps do not break the pattern.
      do_reset(1);
      sample("gap1", 1'b1, 1'b0, 1'b0);
      sample("gap2", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, ~i[0], 1'b0);
         check("gap_idle_match", 32'(m_ov), 32'd0);
      end
      sample("gap3", 1'b1, 1'b0, 1'b0);
      sample("gap4", 1'b1, 1'b1, 1'b1);
      check("gap_count", 32'(cnt_ov), 32'd1);

      // Reset mid-pattern discards partial history.
      do_reset(1);
      sample("mid1", 1'b1, 1'b0, 1'b0);
      sample("mid2", 1'b0, 1'b0, 1'b0);
      sample("mid3", 1'b1, 1'b0, 1'b0);
      do_reset(1);
      check("mid_rst_match", 32'(m_ov), 32'd0);
      sample("mid4", 1'b1, 1'b0, 1'b0);
      sample("mid5", 1'b1, 1'b0, 1'b0);
      sample("mid6", 1'b0, 1'b0, 1'b0);
      sample("mid7", 1'b1, 1'b0, 1'b0);
      sample("mid8", 1'b1, 1'b1, 1'b1);
      check("mid_count", 32'(cnt_ov), 32'd1);

      // Saturation of the 2-bit counter, then clear on the edge of a 5th hit.
      do_reset(1);
      bits    = 16'b1011_0110_1101_1011;
      exp_ov  = 16'b0001_0010_0100_1001;
      exp_nov = 16'b0001_0000_0100_0001;
      exp_sc  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 0};
      exp_so  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
      for (int i = 0; i < 16; i++) begin
         tick(1'b1, bits[15-i], (i == 15) ? 1'b1 : 1'b0);
         check($sformatf("sat_match_%0d", i + 1), 32'(m_ov), 32'(exp_ov[15-i]));
         check($sformatf("sat_nov_match_%0d", i + 1), 32'(m_nov), 32'(exp_nov[15-i]));
         check($sformatf("sat_cnt_%0d", i + 1), 32'(cnt_sat), 32'(exp_sc[i]));
         check($sformatf("sat_ovf_%0d", i + 1), 32'(ovf_sat), 32'(exp_so[i]));
      end
      check("clr_main_count", 32'(cnt_ov), 32'd0);
      check("clr_nov_count", 32'(cnt_nov), 32'd0);

      // Random soak through the flip-flop stage.
      do_reset(1);
      use_ff = 1'b1;
      ff_d   = 1'($urandom_range(0, 1));
      tick(1'b0, 1'b0, 1'b0);
      mh = '0;
      mf = 0;
      mc = 0;
      for (int i = 0; i < 48; i++) begin
         b    = ff_q;
         ff_d = 1'($urandom_range(0, 1));
         mh   = {mh[2:0], b};
         if (mf < 4) mf++;
         e = (mf == 4 && mh == 4'b1011) ? 1'b1 : 1'b0;
         if (e == 1'b1 && mc < 255) mc++;
         exp_q.push_back(e);
         tick(1'b1, 1'b0, 1'b0);
         check($sformatf("soak_match_%0d", i), 32'(m_ov), 32'(exp_q.pop_front()));
      end
      check("soak_count", 32'(cnt_ov), 32'(mc));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_pattern_detector
